sub_fp16: RTL

Pipelined IEEE-754 binary16 subtractor computing a − b with full sign handling, round-to-nearest-even and exception flags. It is the subtract-direction companion to the fp16 adder in the arithmetic library. The sqrt, normalization and accumulation datapaths use it wherever a true difference, including catastrophic cancellation, is required. It has two register stages with a valid/ready handshake on both sides, and accepts one operation per cycle when not stalled.

---
 rtl/sub_fp16_if.sv | 26 ++
 rtl/sub_fp16.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sub_fp16_if.sv
// Handshake and data bundle for the fp16 subtractor.
// The master modport is the producer/consumer side; slave is the subtractor.
`timescale 1ns/1ps
interface sub_fp16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] fp_a;
    logic [15:0] fp_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fp_out;
    logic        ovf;
    logic        unf;
    logic        nx;
    logic        nv;

    modport master (
        output in_valid, fp_a, fp_b, out_ready,
        input  in_ready, out_valid, fp_out, ovf, unf, nx, nv
    );

    modport slave (
        input  in_valid, fp_a, fp_b, out_ready,
        output in_ready, out_valid, fp_out, ovf, unf, nx, nv
    );
endinterface

// File: rtl/sub_fp16.sv
// Two-stage binary16 subtractor a - b: align in S1, add/normalize/round into
// the output register. Subnormal results are flushed to signed zero.
`timescale 1ns/1ps
module sub_fp16 (
    input  logic      clk,
    input  logic      nRST,
    sub_fp16_if.slave bus
);
    logic [15:0] w_a, w_b;
    logic [4:0]  w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [10:0] w_ma, w_mb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic        w_special, w_spec_nv;
    logic [15:0] w_spec_res;
    logic        w_a_big, w_sign, w_sub;
    logic [4:0]  w_e_big, w_e_small, w_diff;
    logic [10:0] w_s_big, w_s_small;
    logic [13:0] w_small14, w_mask, w_aligned;
    logic        w_out_load, w_s1_adv;

    logic        r1_valid, r1_special, r1_spec_nv, r1_sign, r1_sub;
    logic [15:0] r1_spec_res;
    logic [4:0]  r1_exp;
    logic [13:0] r1_big, r1_small;

    logic [14:0]        w_sum;
    logic               w_carry, w_rup, w_rcarry, w_inexact;
    logic [13:0]        w_m0, w_mn;
    logic [3:0]         w_lz;
    logic signed [6:0]  w_exp_n, w_exp_r;
    logic [11:0]        w_mant;
    logic [9:0]         w_frac;
    logic [15:0]        w_res;
    logic               w_ovf, w_unf, w_nx, w_nv;

    logic        r_out_valid, r_ovf, r_unf, r_nx, r_nv;
    logic [15:0] r_fp_out;

    assign w_a      = bus.fp_a;
    assign w_b      = bus.fp_b;
    assign w_ea     = w_a[14:10];
    assign w_eb     = w_b[14:10];
    assign w_ea_eff = (w_ea == 5'd0) ? 5'd1 : w_ea;
    assign w_eb_eff = (w_eb == 5'd0) ? 5'd1 : w_eb;
    assign w_ma     = {|w_ea, w_a[9:0]};
    assign w_mb     = {|w_eb, w_b[9:0]};

    always_comb begin
        w_a_nan    = (&w_ea) & (|w_a[9:0]);
        w_b_nan    = (&w_eb) & (|w_b[9:0]);
        w_a_inf    = (&w_ea) & ~(|w_a[9:0]);
        w_b_inf    = (&w_eb) & ~(|w_b[9:0]);
        w_special  = 1'b0;
        w_spec_nv  = 1'b0;
        w_spec_res = '0;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_a[15] == w_b[15]))) begin
            w_special  = 1'b1;
            w_spec_nv  = 1'b1;
            w_spec_res = 16'h7E00;
        end else if (w_a_inf) begin
            w_special  = 1'b1;
            w_spec_res = {w_a[15], 15'h7C00};
        end else if (w_b_inf) begin
            w_special  = 1'b1;
            w_spec_res = {~w_b[15], 15'h7C00};
        end
    end

    // Effective subtraction when a's sign equals b's raw sign (b is negated).
    always_comb begin
        w_a_big   = (w_a[14:0] >= w_b[14:0]);
        w_sign    = w_a_big ? w_a[15] : ~w_b[15];
        w_sub     = (w_a[15] == w_b[15]);
        w_e_big   = w_a_big ? w_ea_eff : w_eb_eff;
        w_e_small = w_a_big ? w_eb_eff : w_ea_eff;
        w_s_big   = w_a_big ? w_ma : w_mb;
        w_s_small = w_a_big ? w_mb : w_ma;
        w_diff    = w_e_big - w_e_small;
        w_small14 = {w_s_small, 3'b000};
        w_mask    = (14'd1 << w_diff) - 14'd1;
        if (w_diff >= 5'd14) begin
            w_aligned = {13'd0, |w_small14};
        end else begin
            w_aligned = (w_small14 >> w_diff) | {13'd0, |(w_small14 & w_mask)};
        end
    end

    assign w_out_load   = ~r_out_valid | bus.out_ready;
    assign w_s1_adv     = ~r1_valid | w_out_load;
    assign bus.in_ready = w_s1_adv;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r1_valid    <= 1'b0;
            r1_special  <= 1'b0;
            r1_spec_nv  <= 1'b0;
            r1_spec_res <= '0;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_exp      <= '0;
            r1_big      <= '0;
            r1_small    <= '0;
        end else if (w_s1_adv) begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_special  <= w_special;
                r1_spec_nv  <= w_spec_nv;
                r1_spec_res <= w_spec_res;
                r1_sign     <= w_sign;
                r1_sub      <= w_sub;
                r1_exp      <= w_e_big;
                r1_big      <= {w_s_big, 3'b000};
                r1_small    <= w_aligned;
            end
        end
    end

    always_comb begin
        w_sum   = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                         : ({1'b0, r1_big} + {1'b0, r1_small});
        w_carry = ~r1_sub & w_sum[14];
        w_m0    = w_carry ? {w_sum[14:2], w_sum[1] | w_sum[0]} : w_sum[13:0];
        w_lz    = 4'd0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (w_m0[i]) w_lz = 4'(13 - i);
        end
        w_mn      = w_m0 << w_lz;
        w_exp_n   = 7'(r1_exp) + 7'(w_carry) - 7'(w_lz);
        w_inexact = |w_mn[2:0];
        w_rup     = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
        w_mant    = {1'b0, w_mn[13:3]} + 12'(w_rup);
        w_rcarry  = w_mant[11];
        w_exp_r   = w_exp_n + 7'(w_rcarry);
        w_frac    = w_rcarry ? w_mant[10:1] : w_mant[9:0];

        w_res = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_nx  = 1'b0;
        w_nv  = 1'b0;
        if (r1_special) begin
            w_res = r1_spec_res;
            w_nv  = r1_spec_nv;
        end else if (w_m0 == 14'd0) begin
            w_res = {~r1_sub & r1_sign, 15'd0};
        end else if (w_exp_n < 7'sd1) begin
            w_res = {r1_sign, 15'd0};
            w_unf = 1'b1;
            w_nx  = 1'b1;
        end else if (w_exp_r >= 7'sd31) begin
            w_res = {r1_sign, 15'h7C00};
            w_ovf = 1'b1;
            w_nx  = 1'b1;
        end else begin
            w_res = {r1_sign, w_exp_r[4:0], w_frac};
            w_nx  = w_inexact;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_out_valid <= 1'b0;
            r_fp_out    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_nx        <= 1'b0;
            r_nv        <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= r1_valid;
            if (r1_valid) begin
                r_fp_out <= w_res;
                r_ovf    <= w_ovf;
                r_unf    <= w_unf;
                r_nx     <= w_nx;
                r_nv     <= w_nv;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.fp_out    = r_fp_out;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.nx        = r_nx;
    assign bus.nv        = r_nv;
endmodule
